// File: rtl/axi_combine_pkg.sv
// axi_combine_pkg: shared constants, types and helpers for axi_combine.
//   DEFAULT_HALF_WIDTH : half of the default output word width
//   half_width()       : half of an arbitrary (even) word width
//   sign_ext()         : sign-extend a value from a given MSB position
//   occ_t              : FIFO occupancy (0, 1 or 2)
package axi_combine_pkg;

    localparam int unsigned DEFAULT_TDATA_WIDTH = 32;
    localparam int unsigned DEFAULT_HALF_WIDTH  = DEFAULT_TDATA_WIDTH / 2;
    localparam int unsigned EXT_W               = 64;
    localparam int unsigned IDX_W               = 6;

    typedef logic [1:0] occ_t;

    function automatic int unsigned half_width(input int unsigned w);
        return w / 2;
    endfunction

    // Replicate bit 'msb' of x into every higher bit position.
    function automatic logic [EXT_W-1:0] sign_ext(input logic [EXT_W-1:0] x,
                                                 input logic [IDX_W-1:0] msb);
        logic [EXT_W-1:0] r;
        r = x;
        for (int i = 0; i < EXT_W; i++) begin
            if (i > int'(msb)) r[i] = x[msb];
        end
        return r;
    endfunction

endpackage

// File: rtl/axi_combine_fifo.sv
// axi_combine_fifo: 2-entry first-in first-out buffer with registered head.
//   clk, rst     : clock, asynchronous active-high reset
//   push, din    : write request and data (ignored when full without a pop)
//   pop          : read request (ignored when empty)
//   dout         : head entry (registered)
//   full, empty  : occupancy decodes
module axi_combine_fifo
    import axi_combine_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    occ_t             occ;
    logic [WIDTH-1:0] tail;
    logic             do_push;
    logic             do_pop;

    assign full    = (occ == 2'd2);
    assign empty   = (occ == 2'd0);
    assign do_pop  = pop && !empty;
    // A pop frees a slot in the same edge, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);

    // Entry 0 is the head (dout); entry 1 is the tail.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ  <= 2'd0;
            dout <= '0;
            tail <= '0;
        end else if (do_push && do_pop) begin
            if (occ == 2'd1) begin
                dout <= din;
            end else begin
                dout <= tail;
                tail <= din;
            end
        end else if (do_push) begin
            if (empty) dout <= din;
            else       tail <= din;
            occ <= occ + 2'd1;
        end else if (do_pop) begin
            dout <= tail;
            occ  <= occ - 2'd1;
        end
    end

endmodule

// File: rtl/axi_combine.sv
// axi_combine: packs two sign-extended samples into one AXI4-Stream word,
// buffers up to two words and flags dropped pairs.
//   aclk, areset            : clock, asynchronous active-high reset
//   data_lower, data_upper  : channel A / B two's-complement samples
//   in_valid                : sample pair qualifier (no backpressure)
//   m_axis_tdata/tvalid/tready/tlast : AXI4-Stream master
//   clear_ovf               : synchronous clear of overflow
//   overflow                : sticky "a pair was dropped" flag
// Macro AXI_COMBINE_TLAST_EN enables the beat counter and m_axis_tlast;
// without it m_axis_tlast is tied low.
module axi_combine
    import axi_combine_pkg::*;
#(
    parameter int unsigned AXIS_TDATA_WIDTH = 32,
    parameter int unsigned IN_WIDTH         = 14,
    parameter int unsigned FRAME_LEN        = 1024
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [IN_WIDTH-1:0]         data_lower,
    input  logic [IN_WIDTH-1:0]         data_upper,
    input  logic                        in_valid,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    input  logic                        clear_ovf,
    output logic                        overflow
);

    localparam int unsigned HALF_W = half_width(AXIS_TDATA_WIDTH);

    logic [HALF_W-1:0]           lower_ext;
    logic [HALF_W-1:0]           upper_ext;
    logic [AXIS_TDATA_WIDTH-1:0] packed_word;
    logic                        pop;
    logic                        drop;
    logic                        full;
    logic                        empty;

    assign lower_ext   = HALF_W'(sign_ext(EXT_W'(data_lower), IDX_W'(IN_WIDTH - 1)));
    assign upper_ext   = HALF_W'(sign_ext(EXT_W'(data_upper), IDX_W'(IN_WIDTH - 1)));
    assign packed_word = {upper_ext, lower_ext};

    assign m_axis_tvalid = !empty;
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign drop          = in_valid && full && !pop;

    axi_combine_fifo #(
        .WIDTH (AXIS_TDATA_WIDTH)
    ) u_fifo (
        .clk   (aclk),
        .rst   (areset),
        .push  (in_valid),
        .pop   (pop),
        .din   (packed_word),
        .dout  (m_axis_tdata),
        .full  (full),
        .empty (empty)
    );

    // Sticky overflow; a new drop wins over a simultaneous clear.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset)          overflow <= 1'b0;
        else if (drop)       overflow <= 1'b1;
        else if (clear_ovf)  overflow <= 1'b0;
    end

`ifdef AXI_COMBINE_TLAST_EN
    localparam int unsigned     CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

    logic [CNT_W-1:0] beat;
    logic [CNT_W-1:0] beat_next;
    occ_t             occ;
    occ_t             occ_next;
    logic             accepted;

    assign occ      = full ? 2'd2 : (empty ? 2'd0 : 2'd1);
    assign accepted = in_valid && (!full || pop);

    // beat indexes the word currently at the head of the FIFO.
    always_comb begin
        beat_next = beat;
        occ_next  = occ + occ_t'(accepted) - occ_t'(pop);
        if (pop) beat_next = (beat == LAST) ? '0 : beat + CNT_W'(1);
    end

    // tlast is registered against the post-edge head so it holds with tdata.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            beat         <= '0;
            m_axis_tlast <= 1'b0;
        end else begin
            beat         <= beat_next;
            m_axis_tlast <= (occ_next != 2'd0) && (beat_next == LAST);
        end
    end
`else
    assign m_axis_tlast = 1'b0;
`endif

endmodule
